// File: rtl/data_mem.sv
// Word-organised data memory with byte/half/word loads and stores, alignment checking and a sticky fault flag.
// Loads are combinational from the current contents; stores commit at the rising edge.
module data_mem #(
    parameter int DEPTH = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Width,
    input  logic        SignExt,
    output logic [31:0] RData,
    output logic        AlignErr,
    output logic        ErrSticky
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        WIDTH_WORD = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_BYTE = 2'b10,
        WIDTH_RSVD = 2'b11
    } width_e;

    // Access semantics: MemRead/MemWrite qualify the current cycle only; there is no
    // stall or ready. A load is answered in the same cycle, a store lands at the next
    // edge, and a faulting access (AlignErr) is answered with 0 and never writes.

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [1:0]    byte_off;
    logic          access;
    logic          misaligned;
    logic          wr_en;
    logic [3:0]    byte_en;
    logic [31:0]   lane_mask;
    logic [31:0]   wr_lanes;
    logic [31:0]   cur_word;
    logic [31:0]   merged_word;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;
    logic [31:0]   load_val;
    width_e        width_q;
    logic          unused_addr_hi;

    // Upper address bits are intentionally ignored so addresses wrap on the array size.
    assign unused_addr_hi = ^Addr[31:AW+2];

    assign word_idx = Addr[AW+1:2];
    assign byte_off = Addr[1:0];
    assign access   = MemRead | MemWrite;
    assign width_q  = width_e'(Width);
    assign cur_word = mem[word_idx];

    always_comb begin
        misaligned = 1'b0;
        case (width_q)
            WIDTH_WORD: misaligned = (byte_off != 2'b00);
            WIDTH_HALF: misaligned = byte_off[0];
            WIDTH_BYTE: misaligned = 1'b0;
            WIDTH_RSVD: misaligned = 1'b1;
            default:    misaligned = 1'b1;
        endcase
    end

    assign AlignErr = access & misaligned;
    assign wr_en    = MemWrite & ~AlignErr;

    // Store path: replicate the source onto every lane, then let byte_en pick the target lanes.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = WData;
        case (width_q)
            WIDTH_WORD: begin
                byte_en  = 4'b1111;
                wr_lanes = WData;
            end
            WIDTH_HALF: begin
                byte_en  = byte_off[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{WData[15:0]}};
            end
            WIDTH_BYTE: begin
                byte_en  = 4'b0001 << byte_off;
                wr_lanes = {4{WData[7:0]}};
            end
            default: begin
                byte_en  = 4'b0000;
                wr_lanes = WData;
            end
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int l = 0; l < 4; l++) begin
            lane_mask[8*l +: 8] = {8{byte_en[l]}};
        end
    end

    assign merged_word = (cur_word & ~lane_mask) | (wr_lanes & lane_mask);

    // Load path
    always_comb begin
        half_sel = byte_off[1] ? cur_word[31:16] : cur_word[15:0];
        byte_sel = cur_word[8*byte_off +: 8];
        load_val = '0;
        case (width_q)
            WIDTH_WORD: load_val = cur_word;
            WIDTH_HALF: load_val = {{16{SignExt & half_sel[15]}}, half_sel};
            WIDTH_BYTE: load_val = {{24{SignExt & byte_sel[7]}}, byte_sel};
            default:    load_val = '0;
        endcase
        RData = (MemRead && !AlignErr) ? load_val : 32'h0;
    end

    // One register process per word so reset can clear the whole array in a single edge.
    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                mem[g] <= '0;
            end else if (wr_en && (word_idx == AW'(g))) begin
                mem[g] <= merged_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ErrSticky <= 1'b0;
        end else if (AlignErr) begin
            ErrSticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed scenarios plus randomized accesses
// compared against a byte-addressed little-endian reference memory.
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        MemWrite;
    logic        MemRead;
    logic [1:0]  Width;
    logic        SignExt;
    logic [31:0] RData;
    logic        AlignErr;
    logic        ErrSticky;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];

    logic [7:0]  ref_mem [4096];
    logic        ref_sticky;

    always #5 clk = ~clk;

    data_mem #(.DEPTH(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Addr     (Addr),
        .WData    (WData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Width    (Width),
        .SignExt  (SignExt),
        .RData    (RData),
        .AlignErr (AlignErr),
        .ErrSticky(ErrSticky)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic int access_bytes(input logic [1:0] w);
        case (w)
            2'b00:   return 4;
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic ref_fault(input logic rd, input logic wr, input logic [1:0] w,
                                       input logic [31:0] a);
        int n;
        if (!(rd || wr)) return 1'b0;
        n = access_bytes(w);
        if (n == 0) return 1'b1;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic rd, input logic wr, input logic [1:0] w,
                                             input logic se, input logic [31:0] a);
        int          n;
        int          base;
        logic [31:0] v;
        if (!rd || ref_fault(rd, wr, w, a)) return 32'h0;
        n    = access_bytes(w);
        base = int'(a % 4096);
        v    = 0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
        if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
        ref_sticky = 1'b0;
    endtask

    // One cycle: drive, check combinational outputs mid-cycle, step the model at the edge, check sticky.
    task automatic access(input logic rd, input logic wr, input logic [1:0] w, input logic se,
                          input logic [31:0] a, input logic [31:0] d, input logic rst,
                          output logic [31:0] got);
        logic flt;
        int   base;
        rst_n    = ~rst;
        MemRead  = rd;
        MemWrite = wr;
        Width    = w;
        SignExt  = se;
        Addr     = a;
        WData    = d;
        @(negedge clk);
        flt = ref_fault(rd, wr, w, a);
        exp_q.push_back(ref_load(rd, wr, w, se, a));
        got = RData;
        check("rdata", RData, exp_q.pop_front());
        check("alignerr", 32'(AlignErr), 32'(flt));
        @(posedge clk);
        if (rst) begin
            ref_clear();
        end else begin
            if (wr && !flt) begin
                base = int'(a % 4096);
                for (int i = 0; i < access_bytes(w); i++) ref_mem[base + i] = d[8*i +: 8];
            end
            if (flt) ref_sticky = 1'b1;
        end
        #1;
        check("errsticky", 32'(ErrSticky), 32'(ref_sticky));
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  w;

        rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Width = 2'b00;
        SignExt = 1'b0; Addr = '0; WData = '0;
        @(posedge clk);
        #1;
        ref_clear();

        // Reset state
        access(1, 0, 2'b00, 0, 32'h10, 0, 0, got);
        check("reset_lw_0x10", got, 32'h0);
        check("reset_sticky", 32'(ErrSticky), 32'h0);

        // Sub-word loads of a stored word
        access(0, 1, 2'b00, 0, 32'h10, 32'h8899_AABB, 0, got);
        access(1, 0, 2'b10, 1, 32'h13, 0, 0, got);
        check("lb_0x13", got, 32'hFFFF_FF88);
        access(1, 0, 2'b10, 0, 32'h10, 0, 0, got);
        check("lbu_0x10", got, 32'h0000_00BB);
        access(1, 0, 2'b01, 1, 32'h12, 0, 0, got);
        check("lh_0x12", got, 32'hFFFF_8899);
        access(1, 0, 2'b01, 0, 32'h10, 0, 0, got);
        check("lhu_0x10", got, 32'h0000_AABB);

        // Byte store merges into the word
        access(0, 1, 2'b10, 0, 32'h11, 32'h0000_0011, 0, got);
        access(1, 0, 2'b00, 0, 32'h10, 0, 0, got);
        check("sb_merge", got, 32'h8899_11BB);

        // Address wrap
        access(0, 1, 2'b00, 0, 32'h0000_1004, 32'h1234_5678, 0, got);
        access(1, 0, 2'b00, 0, 32'h4, 0, 0, got);
        check("wrap_lw", got, 32'h1234_5678);

        // Same-cycle read and write shows old data, new data the cycle after
        access(1, 1, 2'b00, 0, 32'h4, 32'hCAFE_F00D, 0, got);
        check("rw_old", got, 32'h1234_5678);
        access(1, 0, 2'b00, 0, 32'h4, 0, 0, got);
        check("rw_new", got, 32'hCAFE_F00D);

        // Misaligned store, misaligned half load, reserved width
        access(0, 1, 2'b00, 0, 32'h20, 32'h5555_AAAA, 0, got);
        access(0, 1, 2'b00, 0, 32'h22, 32'hFFFF_FFFF, 0, got);
        check("sticky_set", 32'(ErrSticky), 32'h1);
        access(1, 0, 2'b00, 0, 32'h20, 0, 0, got);
        check("faulting_sw_no_write", got, 32'h5555_AAAA);
        access(1, 0, 2'b01, 1, 32'h21, 0, 0, got);
        check("lh_misaligned_rdata", got, 32'h0);
        access(1, 0, 2'b11, 0, 32'h20, 0, 0, got);
        check("reserved_width", got, 32'h0);

        // Reset beats a same-cycle store
        access(0, 1, 2'b00, 0, 32'h8, 32'hDEAD_BEEF, 1, got);
        access(1, 0, 2'b00, 0, 32'h8, 0, 0, got);
        check("reset_discards_sw", got, 32'h0);
        check("reset_clears_sticky", 32'(ErrSticky), 32'h0);

        // Randomized traffic over a small window, with random upper address bits
        for (int i = 0; i < 600; i++) begin
            a = ($urandom() & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
            w = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if (w == 2'b00 && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if (w == 2'b01 && $urandom_range(0, 3) != 0) a[0] = 1'b0;
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), w,
                   1'($urandom_range(0, 1)), a, $urandom(),
                   $urandom_range(0, 59) == 0, got);
        end

        // Final sweep of the exercised window
        for (int i = 0; i < 16; i++) begin
            access(1, 0, 2'b00, 0, 32'(i * 4), 0, 0, got);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
